complex_alu_pipe: RTL and testbench
===================================

// Module: complex_alu_pipe
// PURPOSE
//   Pipelined, parametrised complex-number ALU with valid/ready handshakes on both sides.
//   Operands and result are packed complex values: {real[2W-1:W], imag[W-1:0]}, signed two's complement.
//   Adds conjugate multiply, magnitude-squared, complex MAC, fixed-point scaling and optional saturation.
//   Sits between a sample source and a downstream DSP stage; fixed 2-cycle latency, full throughput.
// PARAMETERS
//   W     16  component width in bits (real and imag each); bus width is 2W
//   FRAC  0   product right-shift (arithmetic, truncating) for Q-format; 0..W-1; applies to ops 2-6 only
//   SAT   1   1 = saturate each component to [-2^(W-1), 2^(W-1)-1]; 0 = wrap (modulo 2^W)
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous reset, active-high
//   in_valid   in   1   operand beat valid
//   in_ready   out  1   block can accept a beat this cycle
//   opcode     in   4   operation select, sampled with the beat
//   operand1   in   2W  complex A = {ar, ai}
//   operand2   in   2W  complex B = {br, bi}
//   out_valid  out  1   result beat valid
//   out_ready  in   1   downstream accepts result
//   result     out  2W  complex R = {rr, ri}
//   out_ovf    out  1   saturation (SAT=1) or wrap (SAT=0) occurred in this beat, either component
//   out_err    out  1   beat carried an illegal opcode
// BEHAVIOUR
//   Opcodes: 0 ADD R=A+B | 1 SUB R=A-B | 2 MUL R=A*B: rr=ar*br-ai*bi, ri=ar*bi+ai*br
//     3 CMULC R=A*conj(B): rr=ar*br+ai*bi, ri=ai*br-ar*bi | 4 MAGSQ rr=ar^2+ai^2, ri=0 (B ignored)
//     5 MAC ACC=ACC+A*B, R=new ACC | 6 MACLD ACC=A*B, R=new ACC | 7-15 illegal: R=0, out_err=1, ACC unchanged.
//   Widths: products 2W bits, sums 2W+1 bits, full precision; then >>>FRAC (ops 2-6), then SAT/wrap to W.
//   MAC: ACC (2W bits, {accr, acci}) adds to the shifted product at full precision, then the sum is SAT/wrapped
//     to W bits per component; ACC stores the saturated/wrapped value. out_ovf reflects that final step.
//   Pipeline: S1 registers the four partial products / raw sums + opcode; S2 combines, scales,
//     saturates, updates ACC and drives result/out_ovf/out_err (all registered outputs).
//   Advance enable en = ~out_valid | out_ready; in_ready = en & ~rst (combinational).
//   Beat accepted on edge where in_valid & in_ready. Accepted at edge N -> out_valid=1 after edge N+2 (no stall).
//   Stall (out_valid & ~out_ready): S1, S2, ACC, result, out_ovf, out_err all hold; in_ready=0.
//   Bubbles: S1 valid bit clears when en & ~in_valid; bubbles advance and never touch ACC.
//   ACC updates only on the edge its MAC/MACLD beat loads S2; back-to-back MAC beats chain with no gap.
//   Result stays stable while out_valid & ~out_ready (AXI-style hold).
//   Reset (any cycle, incl. mid-stall or mid-MAC): out_valid=0, result=0, out_ovf=0, out_err=0, ACC=0,
//     S1 valid=0; in-flight beats discarded; in_ready=1 on first cycle after rst deasserts.
// TESTING (W=16, FRAC=0, SAT=1 unless stated)
//   ADD (3,4)+(1,-2) -> (4,2); SUB same -> (2,6); MUL -> (11,-2); CMULC -> (-5,10); MAGSQ A=(3,4) -> (25,0),
//     each out_valid exactly 2 cycles after acceptance, out_ovf=0.
//   ADD (32767,0)+(1,0) -> (32767,0), out_ovf=1; repeat SAT=0 -> (-32768,0), out_ovf=1; FRAC=15 MUL
//     (16384,0)*(16384,0) -> (8192,0).
//   MACLD (1,1)*(1,0) -> (1,1); MAC (2,0)*(0,1) -> (1,3); MAC (0,0)*(5,5) -> (1,3); back-to-back, 1 beat/cycle.
//   Backpressure: stream 8 ADD beats, out_ready=0 for 5 cycles mid-stream -> in_ready=0 during stall,
//     result held stable, all 8 results delivered in order, none dropped or duplicated.
//   Opcode 9 -> result 0, out_err=1, following MAC shows ACC unchanged.
//   Assert rst with 2 beats in flight and ACC=(1,3) -> next cycle out_valid=0; MAC (1,0)*(1,0) -> (1,0).

Source files
------------

// File: rtl/complex_alu_pipe.sv
// complex_alu_pipe: pipelined complex ALU (add/sub/mul/conj-mul/magsq/MAC) with Q-format scaling and saturation
module complex_alu_pipe #(
   parameter int W    = 16,
   parameter int FRAC = 0,
   parameter int SAT  = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     opcode,
   input  logic [2*W-1:0] operand1,
   input  logic [2*W-1:0] operand2,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] result,
   output logic           out_ovf,
   output logic           out_err
);
   localparam int L = 2 * W + 2;
   logic                  en;
   logic                  s0_valid, s1_valid;
   logic [3:0]            s0_op, s1_op;
   logic [2*W-1:0]        s0_a, s0_b;
   logic [W-1:0]          ar, ai, br, bi, mr, mi;
   logic signed [2*W-1:0] arx, aix, mrx, mix;
   logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic [W:0]            s1_sr, s1_si;
   logic signed [L-1:0]   xrr, xii, xri, xir, pre_r, pre_i, sh_r, sh_i, v_r, v_i;
   logic [W:0]            c_r, c_i;
   logic [2*W-1:0]        acc;
   logic                  legal, add_op, mac_op, ld_acc;

   // narrows a full-precision value to W bits; MSB of the return flags out-of-range
   function automatic logic [W:0] clip(input logic signed [L-1:0] v);
      logic ovf;
      ovf = v[L-1:W-1] != {(L-W+1){v[W-1]}};
      return {ovf, (ovf && SAT != 0) ? {v[L-1], {(W-1){~v[L-1]}}} : v[W-1:0]};
   endfunction

   assign en       = ~out_valid | out_ready;
   assign in_ready = en & ~rst;
   assign {ar, ai} = s0_a;
   assign {br, bi} = s0_b;
   assign mr       = s0_op == 4'd4 ? ar : br;
   assign mi       = s0_op == 4'd4 ? ai : bi;
   assign arx      = {{W{ar[W-1]}}, ar};
   assign aix      = {{W{ai[W-1]}}, ai};
   assign mrx      = {{W{mr[W-1]}}, mr};
   assign mix      = {{W{mi[W-1]}}, mi};

   // operand capture so the multipliers are fed straight from flops
   always_ff @(posedge clk)
      if (rst) s0_valid <= 1'b0;
      else if (en) begin
         s0_valid <= in_valid;
         s0_op    <= opcode;
         s0_a     <= operand1;
         s0_b     <= operand2;
      end

   // four partial products (MAGSQ squares A by substituting B=A) and raw add/sub sums
   always_ff @(posedge clk)
      if (rst) s1_valid <= 1'b0;
      else if (en) begin
         s1_valid <= s0_valid;
         s1_op    <= s0_op;
         p_rr     <= arx * mrx;
         p_ii     <= aix * mix;
         p_ri     <= arx * mix;
         p_ir     <= aix * mrx;
         s1_sr    <= s0_op == 4'd1 ? {ar[W-1], ar} - {br[W-1], br} : {ar[W-1], ar} + {br[W-1], br};
         s1_si    <= s0_op == 4'd1 ? {ai[W-1], ai} - {bi[W-1], bi} : {ai[W-1], ai} + {bi[W-1], bi};
      end

   // combine products, scale, add accumulator for MAC, then narrow to W bits
   always_comb begin
      xrr    = {{2{p_rr[2*W-1]}}, p_rr};
      xii    = {{2{p_ii[2*W-1]}}, p_ii};
      xri    = {{2{p_ri[2*W-1]}}, p_ri};
      xir    = {{2{p_ir[2*W-1]}}, p_ir};
      pre_r  = (s1_op == 4'd3 || s1_op == 4'd4) ? xrr + xii : xrr - xii;
      pre_i  = s1_op == 4'd4 ? '0 : s1_op == 4'd3 ? xir - xri : xri + xir;
      sh_r   = pre_r >>> FRAC;
      sh_i   = pre_i >>> FRAC;
      add_op = s1_op < 4'd2;
      mac_op = s1_op == 4'd5;
      ld_acc = mac_op || s1_op == 4'd6;
      legal  = s1_op < 4'd7;
      v_r    = add_op ? {{(L-W-1){s1_sr[W]}}, s1_sr} : mac_op ? sh_r + {{(L-W){acc[2*W-1]}}, acc[2*W-1:W]} : sh_r;
      v_i    = add_op ? {{(L-W-1){s1_si[W]}}, s1_si} : mac_op ? sh_i + {{(L-W){acc[W-1]}}, acc[W-1:0]} : sh_i;
      c_r    = clip(v_r);
      c_i    = clip(v_i);
   end

   // registered outputs and accumulator; everything holds while the consumer stalls
   always_ff @(posedge clk)
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
         acc       <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result  <= legal ? {c_r[W-1:0], c_i[W-1:0]} : '0;
            out_ovf <= legal & (c_r[W] | c_i[W]);
            out_err <= ~legal;
            if (ld_acc) acc <= {c_r[W-1:0], c_i[W-1:0]};
         end
      end
endmodule

// File: tb/tb_complex_alu_pipe.sv
// tb_complex_alu_pipe: directed and randomized checks of three ALU configurations against a behavioural model
module tb_complex_alu_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  opcode = '0;
   logic [31:0] operand1 = '0, operand2 = '0;
   logic [2:0]  rdy, ov, ovf, err;
   logic [31:0] res [3];
   int          n_chk = 0, n_pass = 0, n_out = 0;
   int          frac [3] = '{0, 0, 15};
   int          sat [3] = '{1, 0, 1};
   longint      acc_r [3], acc_i [3];
   logic [33:0] q [3][$];
   logic [31:0] ma [3] = '{32'h0001_0001, 32'h0002_0000, 32'h0000_0000};
   logic [31:0] mb [3] = '{32'h0001_0000, 32'h0000_0001, 32'h0005_0005};
   logic [31:0] me [3] = '{32'h0001_0001, 32'h0001_0003, 32'h0001_0003};

   always #5 clk = ~clk;

   complex_alu_pipe #(.W(16), .FRAC(0), .SAT(1)) u_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
      .opcode(opcode), .operand1(operand1), .operand2(operand2), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res[0]), .out_ovf(ovf[0]), .out_err(err[0]));
   complex_alu_pipe #(.W(16), .FRAC(0), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
      .opcode(opcode), .operand1(operand1), .operand2(operand2), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res[1]), .out_ovf(ovf[1]), .out_err(err[1]));
   complex_alu_pipe #(.W(16), .FRAC(15), .SAT(1)) u_q15 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
      .opcode(opcode), .operand1(operand1), .operand2(operand2), .out_valid(ov[2]), .out_ready(out_ready),
      .result(res[2]), .out_ovf(ovf[2]), .out_err(err[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // 16-bit narrowing: {overflow, value}
   function automatic logic [16:0] fit(input longint v, input int s);
      logic [15:0] lo;
      lo = v[15:0];
      if (v > 32767) return {1'b1, s != 0 ? 16'h7fff : lo};
      if (v < -32768) return {1'b1, s != 0 ? 16'h8000 : lo};
      return {1'b0, lo};
   endfunction

   // reference: expected {err, ovf, result} for instance k, queued in acceptance order
   task automatic model(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ar, ai, br, bi, r, i;
      int f;
      logic [16:0] fr, fi;
      f  = frac[k];
      ar = longint'($signed(a[31:16]));
      ai = longint'($signed(a[15:0]));
      br = longint'($signed(b[31:16]));
      bi = longint'($signed(b[15:0]));
      case (op)
         4'd0: begin r = ar + br; i = ai + bi; end
         4'd1: begin r = ar - br; i = ai - bi; end
         4'd2: begin r = (ar * br - ai * bi) >>> f; i = (ar * bi + ai * br) >>> f; end
         4'd3: begin r = (ar * br + ai * bi) >>> f; i = (ai * br - ar * bi) >>> f; end
         4'd4: begin r = (ar * ar + ai * ai) >>> f; i = 0; end
         4'd5: begin r = ((ar * br - ai * bi) >>> f) + acc_r[k]; i = ((ar * bi + ai * br) >>> f) + acc_i[k]; end
         4'd6: begin r = (ar * br - ai * bi) >>> f; i = (ar * bi + ai * br) >>> f; end
         default: begin q[k].push_back({2'b10, 32'h0}); return; end
      endcase
      fr = fit(r, sat[k]);
      fi = fit(i, sat[k]);
      if (op >= 4'd5) begin
         acc_r[k] = longint'($signed(fr[15:0]));
         acc_i[k] = longint'($signed(fi[15:0]));
      end
      q[k].push_back({1'b0, fr[16] | fi[16], fr[15:0], fi[15:0]});
   endtask

   // scoreboard step, run at every falling edge
   task automatic sb();
      logic [33:0] e;
      if (rst) begin
         for (int k = 0; k < 3; k++) begin q[k].delete(); acc_r[k] = 0; acc_i[k] = 0; end
         return;
      end
      if (in_valid && rdy[0]) for (int k = 0; k < 3; k++) model(k, opcode, operand1, operand2);
      for (int k = 0; k < 3; k++)
         if (ov[k] && out_ready) begin
            if (k == 0) n_out++;
            e = q[k].size() != 0 ? q[k].pop_front() : '1;
            chk($sformatf("sb%0d", k), {err[k], ovf[k], res[k]}, e);
         end
   endtask

   task automatic neg(); @(negedge clk); sb(); endtask
   task automatic pos(); @(posedge clk); #1; endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
      for (int t = 0; t < 50 && !ok; t++) begin neg(); ok = rdy[0]; pos(); end
      in_valid = 1'b0;
      chk("send_accept", ok, 1);
   endtask

   // one beat with exact-latency check; m selects which instances get a directed compare
   task automatic one(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] m, input logic [33:0] e0, input logic [33:0] e1, input logic [33:0] e2);
      logic [33:0] e [3];
      e = '{e0, e1, e2};
      send(op, a, b);
      neg(); pos();
      neg(); chk({tag, "_lat1"}, ov[0], 0); pos();
      neg(); chk({tag, "_lat2"}, ov[0], 1);
      for (int k = 0; k < 3; k++) if (m[k]) chk($sformatf("%s_%0d", tag, k), {err[k], ovf[k], res[k]}, e[k]);
      pos();
   endtask

   function automatic logic [31:0] rnd_c();
      if ($urandom_range(0, 1) != 0) return $urandom;
      return {16'($urandom_range(0, 15)) - 16'd8, 16'($urandom_range(0, 15)) - 16'd8};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [31:0] held;
      int n0;
      repeat (3) begin neg(); pos(); end
      neg(); chk("rst_valid", ov, 0); chk("rst_res", res[0], 0); chk("rst_flags", {ovf, err}, 0); pos();
      rst = 1'b0;
      neg(); chk("rst_ready", rdy, 3'b111); pos();
      one("add", 0, 32'h0003_0004, 32'h0001_fffe, 3'b111, 34'h0_0004_0002, 34'h0_0004_0002, 34'h0_0004_0002);
      one("sub", 1, 32'h0003_0004, 32'h0001_fffe, 3'b111, 34'h0_0002_0006, 34'h0_0002_0006, 34'h0_0002_0006);
      one("mul", 2, 32'h0003_0004, 32'h0001_fffe, 3'b111, 34'h0_000b_fffe, 34'h0_000b_fffe, 34'h0_0000_ffff);
      one("cmulc", 3, 32'h0003_0004, 32'h0001_fffe, 3'b111, 34'h0_fffb_000a, 34'h0_fffb_000a, 34'h0_ffff_0000);
      one("magsq", 4, 32'h0003_0004, 32'h1234_5678, 3'b111, 34'h0_0019_0000, 34'h0_0019_0000, 34'h0_0000_0000);
      one("add_ovf", 0, 32'h7fff_0000, 32'h0001_0000, 3'b111, 34'h1_7fff_0000, 34'h1_8000_0000, 34'h1_7fff_0000);
      one("mul_q15", 2, 32'h4000_0000, 32'h4000_0000, 3'b111, 34'h1_7fff_0000, 34'h1_0000_0000, 34'h0_2000_0000);
      // MACLD then two MACs, one beat per cycle
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1; opcode = j == 0 ? 4'd6 : 4'd5; operand1 = ma[j]; operand2 = mb[j];
         neg(); chk("mac_rdy", rdy[0], 1); pos();
      end
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin neg(); chk("mac_v", ov[0], 1); chk("mac_r", res[0], me[j]); pos(); end
      one("ill", 9, 32'h1111_2222, 32'h3333_4444, 3'b111, 34'h2_0000_0000, 34'h2_0000_0000, 34'h2_0000_0000);
      one("mac_hold", 5, 32'h0, 32'h0, 3'b001, 34'h0_0001_0003, 34'h0, 34'h0);
      // backpressure mid-stream
      n0 = n_out;
      for (int j = 0; j < 8; j++) begin
         send(4'd0, {16'(j * 1000), 16'(j)}, {16'(j), 16'hffff});
         if (j == 3) begin
            out_ready = 1'b0;
            for (int t = 0; t < 5; t++) begin
               neg(); chk("bp_rdy", rdy[0], 0); chk("bp_v", ov[0], 1);
               if (t == 0) held = res[0];
               else chk("bp_hold", res[0], held);
               pos();
            end
            out_ready = 1'b1;
         end
      end
      repeat (4) begin neg(); pos(); end
      chk("bp_count", n_out - n0, 8);
      // reset with two MAC beats in flight and ACC=(1,3)
      for (int j = 0; j < 2; j++) begin
         in_valid = 1'b1; opcode = 4'd5; operand1 = 32'h0001_0001; operand2 = 32'h0001_0001; neg(); pos();
      end
      in_valid = 1'b0; rst = 1'b1;
      neg(); pos();
      rst = 1'b0;
      neg(); chk("rst_mid_v", ov[0], 0); chk("rst_mid_rdy", rdy[0], 1); pos();
      one("mac_rst", 5, 32'h0001_0000, 32'h0001_0000, 3'b001, 34'h0_0001_0000, 34'h0, 34'h0);
      // randomized traffic with random backpressure and one reset
      for (int c = 0; c < 400; c++) begin
         rst = c == 200;
         in_valid = $urandom_range(0, 3) != 0;
         opcode = $urandom_range(0, 7) == 0 ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
         operand1 = rnd_c();
         operand2 = rnd_c();
         out_ready = $urandom_range(0, 3) != 0;
         neg(); pos();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) begin neg(); pos(); end
      for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), q[k].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
